// File: rtl/snn_img_loader.sv
// Image loader: unpacks UART bytes LSB-first into the 1024x1 input RAM,
// starts the core after a full image and holds off new images until done.
module snn_img_loader #(
    parameter int NUM_BITS    = 784,
    parameter int ADDR_W      = 10,
    parameter int TIMEOUT_CYC = 2_500_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_rdy,
    input  logic              core_done,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_data,
    output logic              core_start,
    output logic              busy,
    output logic              timeout_err,
    output logic              overrun_err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SHIFT = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_START = 3'd3;
    localparam logic [2:0] S_RUN   = 3'd4;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BITS - 1);
    localparam logic [TW-1:0]     TMO_LAST  = TW'(TIMEOUT_CYC - 1);

    logic [2:0]        state;
    logic [7:0]        sh;
    logic [2:0]        bcnt;
    logic [ADDR_W-1:0] addr;
    logic [TW-1:0]     tcnt;

    // All outputs decode straight from state/registers; no path from rx_rdy.
    assign wr_en      = (state == S_SHIFT);
    assign wr_addr    = addr;
    assign wr_data    = sh[0];
    assign core_start = (state == S_START);
    assign busy       = (state == S_START) || (state == S_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            sh          <= '0;
            bcnt        <= '0;
            addr        <= '0;
            tcnt        <= '0;
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    addr <= '0;
                    if (rx_rdy) begin
                        sh    <= rx_data;
                        bcnt  <= '0;
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    sh   <= sh >> 1;
                    bcnt <= bcnt + 3'd1;
                    if (rx_rdy) begin
                        overrun_err <= 1'b1;
                    end
                    // Address holds on the final image bit so it never wraps.
                    if (bcnt == 3'd7) begin
                        if (addr == LAST_ADDR) begin
                            state <= S_START;
                        end else begin
                            addr  <= addr + ADDR_W'(1);
                            tcnt  <= '0;
                            state <= S_WAIT;
                        end
                    end else begin
                        addr <= addr + ADDR_W'(1);
                    end
                end
                S_WAIT: begin
                    if (rx_rdy) begin
                        sh    <= rx_data;
                        bcnt  <= '0;
                        state <= S_SHIFT;
                    end else if (tcnt == TMO_LAST) begin
                        addr        <= '0;
                        timeout_err <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                S_START: begin
                    if (rx_rdy) begin
                        overrun_err <= 1'b1;
                    end
                    state <= S_RUN;
                end
                S_RUN: begin
                    if (rx_rdy) begin
                        overrun_err <= 1'b1;
                    end
                    if (core_done) begin
                        addr  <= '0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    addr  <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snn_img_loader.sv
// Scoreboard bench for snn_img_loader: expected RAM writes are queued as
// bytes are sent and popped as the loader writes them.
module tb_snn_img_loader;

    localparam int TO = 200;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_rdy = 1'b0;
    logic       core_done = 1'b0;
    logic       wr_en;
    logic [9:0] wr_addr;
    logic       wr_data;
    logic       core_start;
    logic       busy;
    logic       timeout_err;
    logic       overrun_err;

    snn_img_loader #(
        .NUM_BITS(784),
        .ADDR_W(10),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx_data(rx_data),
        .rx_rdy(rx_rdy),
        .core_done(core_done),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .core_start(core_start),
        .busy(busy),
        .timeout_err(timeout_err),
        .overrun_err(overrun_err)
    );

    always #10 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int n_start = 0;
    int n_tmo = 0;
    int n_ovr = 0;
    logic last783 = 1'b0;
    logic [10:0] q[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [10:0] e;
        if (rst_n) begin
            if (wr_en) begin
                e = (q.size() > 0) ? q.pop_front() : 11'h7FF;
                chk("wr", {21'b0, wr_addr, wr_data}, {21'b0, e});
            end
            if (core_start) begin
                n_start++;
                chk("start_lat", {31'b0, last783}, 32'd1);
            end
            if (timeout_err) n_tmo++;
            if (overrun_err) n_ovr++;
            last783 = wr_en && (wr_addr == 10'd783);
        end
    end

    task automatic send(input logic [7:0] b, input int base);
        @(negedge clk);
        rx_data = b;
        rx_rdy = 1'b1;
        if (base >= 0)
            for (int k = 0; k < 8; k++)
                q.push_back({10'(base + k), b[k]});
        @(negedge clk);
        rx_rdy = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {20'b0, wr_en, wr_addr, wr_data, core_start, busy,
                  timeout_err, overrun_err}, 32'd0);
    endtask

    initial begin
        idle(3);
        chk_zero("rst_outs");
        rst_n = 1'b1;
        idle(2);
        chk_zero("idle_outs");

        // full image of 0xA5
        for (int i = 0; i < 98; i++) begin
            send(8'hA5, i * 8);
            idle(100);
        end
        chk("img_q", q.size(), 0);
        chk("img_start", n_start, 1);
        chk("img_busy", {31'b0, busy}, 32'd1);

        // byte during RUN is dropped
        send(8'h3C, -1);
        idle(12);
        chk("run_ovr", n_ovr, 1);
        chk("run_busy", {31'b0, busy}, 32'd1);
        @(negedge clk);
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        chk("done_busy", {31'b0, busy}, 32'd0);

        // 40 bytes then an idle gap: partial image discarded
        for (int i = 0; i < 40; i++) begin
            send(8'h3C + 8'(i), i * 8);
            idle(12);
        end
        chk("part_q", q.size(), 0);
        chk("part_tmo0", n_tmo, 0);
        idle(TO + 20);
        chk("part_tmo", n_tmo, 1);
        chk("part_start", n_start, 1);

        // overrun landing in SHIFT leaves the byte intact
        send(8'hFF, 0);
        @(negedge clk);
        send(8'h00, -1);
        idle(10);
        chk("sh_ovr", n_ovr, 2);
        send(8'h81, 8);

        // byte on the very last timeout cycle is accepted
        idle(8 + TO - 2);
        send(8'h6E, 16);
        idle(12);
        chk("edge_tmo", n_tmo, 1);
        chk("edge_q", q.size(), 0);

        // reset in the middle of a byte at addr 300
        for (int a = 24; a < 296; a += 8) begin
            send(8'h96, a);
            idle(10);
        end
        for (int k = 0; k < 4; k++)
            q.push_back({10'(296 + k), 1'(k & 1)});
        send(8'h5A, -1);
        idle(3);
        @(posedge clk);
        #1;
        chk("pre_rst_addr", {22'b0, wr_addr}, 32'd300);
        chk("pre_rst_q", q.size(), 0);
        rst_n = 1'b0;
        #1;
        chk_zero("mid_rst_outs");
        q.delete();
        idle(3);
        rst_n = 1'b1;
        idle(2);
        send(8'hC3, 0);
        idle(12);
        chk("post_rst_q", q.size(), 0);
        chk("end_start", n_start, 1);
        chk("end_ovr", n_ovr, 2);
        chk("end_tmo", n_tmo, 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/snn_img_loader.md
Name: snn_img_loader

Overview:
- Upstream stage of the digit-recognition core. Consumes bytes from the UART receiver and unpacks each byte LSB-first into single-bit writes to the 1024x1 input-image RAM.
- After a full 28x28 image (784 bits, 98 bytes) has been written, it issues a one-cycle start to the core and holds off new images until the core reports done.
- Provides inter-byte timeout resynchronisation and overrun flagging, so a dropped or extra byte cannot misalign later images.

Parameters:
- NUM_BITS, 784, image size in bits. Must be a multiple of 8 and no larger than 2**ADDR_W.
- ADDR_W, 10, RAM address width.
- TIMEOUT_CYC, 2_500_000, idle clock cycles allowed between bytes of one image before the partial image is discarded. Default is 50 ms at 50 MHz.

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- rx_data  in  8  received byte; valid only when rx_rdy is high
- rx_rdy  in  1  one-cycle pulse, byte available
- core_done  in  1  one-cycle pulse from the core, classification finished
- wr_en  out  1  RAM write enable
- wr_addr  out  ADDR_W  RAM write address
- wr_data  out  1  RAM write data bit
- core_start  out  1  one-cycle pulse, image complete
- busy  out  1  high from core_start until core_done
- timeout_err  out  1  one-cycle pulse, partial image discarded
- overrun_err  out  1  one-cycle pulse, byte dropped

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Write address counter, bit counter, shift register and timeout counter all 0.
- Registers:
  - sh[7:0]: byte shift register.
  - bcnt[2:0]: bit counter.
  - addr[ADDR_W-1:0]: write address.
  - tcnt: timeout counter, wide enough to hold TIMEOUT_CYC.
- Outputs are driven from these registers and the state, with no combinational path from rx_rdy:
  - wr_addr = addr.
  - wr_data = sh[0].
  - wr_en = 1 only in SHIFT.
- IDLE:
  - addr = 0.
  - rx_rdy: sh <= rx_data, bcnt <= 0, go to SHIFT.
  - First wr_en occurs the cycle after rx_rdy.
- SHIFT: one bit written per cycle, 8 consecutive cycles. Each cycle:
  - sh <= sh >> 1.
  - bcnt++.
  - addr++, except on the last bit of the image.
- SHIFT exit, on bcnt == 7:
  - If addr == NUM_BITS-1, go to START; addr holds.
  - Otherwise go to WAIT_BYTE with tcnt <= 0.
- SHIFT, rx_rdy during the state: the byte is dropped, overrun_err pulses the next cycle, and shifting continues unaffected.
- WAIT_BYTE:
  - tcnt increments each cycle.
  - rx_rdy: sh <= rx_data, bcnt <= 0, go to SHIFT. rx_rdy has priority over timeout in the same cycle.
  - tcnt == TIMEOUT_CYC-1 without rx_rdy: go to IDLE, addr <= 0, timeout_err pulses one cycle.
- START:
  - core_start = 1 for exactly this cycle.
  - busy = 1.
  - Next state RUN.
- RUN:
  - busy = 1.
  - rx_rdy: byte dropped, overrun_err pulses.
  - core_done: go to IDLE, busy falls the next cycle, addr <= 0.
  - rx_rdy in the same cycle as core_done is dropped with overrun_err.
- core_done in any state other than RUN is ignored.
- Address wrap: addr never exceeds NUM_BITS-1, so there is no wrap through 2**ADDR_W.
- Reset mid-operation: asynchronous return to IDLE with all outputs 0. A partially written RAM is not cleared; the next image overwrites it fully.
- Throughput: a 98-byte image takes 98x8 write cycles plus byte gaps. The START to core_start latency is 1 cycle after the last write.

Test Plan:
- Reset, then send 98 bytes 0xA5 with 100-cycle gaps. Required:
  - 784 writes at addresses 0..783.
  - wr_data pattern per byte is 1,0,1,0,0,1,0,1.
  - core_start pulses once, 1 cycle after the addr=783 write.
  - busy = 1 until core_done.
- Send 40 bytes, then idle TIMEOUT_CYC cycles. Required:
  - timeout_err pulses once.
  - The next byte 0xFF writes addresses 0..7 with data 1.
- During RUN, pulse rx_rdy with 0x3C. Required:
  - overrun_err pulses.
  - No wr_en.
  - After core_done, a new image starts writing at addr 0.
- Pulse rx_rdy 3 cycles after a previous rx_rdy, landing in SHIFT. Required:
  - overrun_err pulses.
  - The original byte's 8 writes complete unchanged.
  - addr advances by 8 only.
- In WAIT_BYTE, assert rx_rdy in the same cycle tcnt reaches TIMEOUT_CYC-1. Required:
  - The byte is accepted with no timeout_err.
  - Writes continue at the next address.
- Assert rst_n low mid-SHIFT at addr 300. Required:
  - All outputs 0 immediately.
  - After release, the next byte writes starting at addr 0.
